// File: rtl/aftab_load_sequencer_if.sv
`default_nettype none
// ============================================================================
// Module      : aftab_load_sequencer_if
// Description : Bundles the load request, the data-memory read port and the
//               SULU-facing result/status signals of the load sequencer.
//               master : the requester / memory / SULU side
//               slave  : the load sequencer itself
// Revision    : 1.0 - initial release
// ============================================================================
interface aftab_load_sequencer_if #(
    parameter int SIZE = 32
);
    logic            startLoad;
    logic [2:0]      funct3;
    logic [SIZE-1:0] addrIn;
    logic [SIZE-1:0] memAddr;
    logic            memRead;
    logic            memReady;
    logic [SIZE-1:0] memDataIn;
    logic [SIZE-1:0] suluDataIn;
    logic            loadByteSigned;
    logic            loadHalfSigned;
    logic            load;
    logic            done;
    logic            misaligned;
    logic            illegalLoad;
    logic            busError;
    logic            busy;

    modport master (
        output startLoad, funct3, addrIn, memReady, memDataIn,
        input  memAddr, memRead, suluDataIn, loadByteSigned, loadHalfSigned,
               load, done, misaligned, illegalLoad, busError, busy
    );

    modport slave (
        input  startLoad, funct3, addrIn, memReady, memDataIn,
        output memAddr, memRead, suluDataIn, loadByteSigned, loadHalfSigned,
               load, done, misaligned, illegalLoad, busError, busy
    );
endinterface
`default_nettype wire

// File: rtl/aftab_load_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : aftab_load_sequencer
// Description : Runs each load through legality/alignment checks, a single
//               word-aligned memory read with timeout, and lane extraction for
//               the SULU. Results and error pulses last one cycle.
// Ports       : clk    - system clock, rising edge
//               rst_n  - asynchronous active-low reset
//               bus    - aftab_load_sequencer_if.slave (request, memory port,
//                        SULU data/selects, status pulses, busy)
// Revision    : 1.0 - initial release
// ============================================================================
module aftab_load_sequencer #(
    parameter int SIZE           = 32,
    parameter int TIMEOUT_CYCLES = 16
) (
    input  wire logic                clk,
    input  wire logic                rst_n,
    aftab_load_sequencer_if.slave    bus
);

    localparam logic [1:0] c_IDLE = 2'd0;
    localparam logic [1:0] c_REQ  = 2'd1;
    localparam logic [1:0] c_DONE = 2'd2;
    localparam logic [1:0] c_ERR  = 2'd3;

    localparam logic [7:0] c_TIMEOUT = 8'(TIMEOUT_CYCLES);

    logic [1:0]      r_state;
    logic [7:0]      r_cnt;
    logic [2:0]      r_funct3;
    logic [1:0]      r_lane;
    logic [SIZE-1:0] r_mem_addr;
    logic [SIZE-1:0] r_sulu;
    logic            r_misaligned;
    logic            r_illegal;
    logic            r_bus_err;

    logic            w_illegal;
    logic            w_misaligned;
    logic [SIZE-1:0] w_byte_shift;
    logic [SIZE-1:0] w_half_shift;
    logic [SIZE-1:0] w_lane_data;

    // Legality and alignment are judged on the live request inputs, since
    // the decision is made in the same edge that latches them.
    always_comb begin
        w_illegal    = (bus.funct3 == 3'b011) || (bus.funct3 == 3'b110) ||
                       (bus.funct3 == 3'b111);
        w_misaligned = 1'b0;
        case (bus.funct3[1:0])
            2'b01:   w_misaligned = bus.addrIn[0];
            2'b10:   w_misaligned = (bus.addrIn[1:0] != 2'b00);
            default: w_misaligned = 1'b0;
        endcase
    end

    // Lane extraction from the word being captured. Unsigned and signed
    // variants share the zero mask; the SULU does the sign extension.
    always_comb begin
        w_byte_shift = bus.memDataIn >> {r_lane, 3'b000};
        w_half_shift = bus.memDataIn >> {r_lane[1], 4'b0000};
        case (r_funct3[1:0])
            2'b00:   w_lane_data = w_byte_shift & 32'h0000_00FF;
            2'b01:   w_lane_data = w_half_shift & 32'h0000_FFFF;
            default: w_lane_data = bus.memDataIn;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= c_IDLE;
            r_cnt        <= 8'd0;
            r_funct3     <= 3'b000;
            r_lane       <= 2'b00;
            r_mem_addr   <= '0;
            r_sulu       <= '0;
            r_misaligned <= 1'b0;
            r_illegal    <= 1'b0;
            r_bus_err    <= 1'b0;
        end else begin
            // Error flags are pulses: only the edge entering ERR sets one.
            r_misaligned <= 1'b0;
            r_illegal    <= 1'b0;
            r_bus_err    <= 1'b0;
            case (r_state)
                c_IDLE: begin
                    r_sulu <= '0;
                    if (bus.startLoad) begin
                        r_funct3   <= bus.funct3;
                        r_lane     <= bus.addrIn[1:0];
                        r_mem_addr <= {bus.addrIn[SIZE-1:2], 2'b00};
                        r_cnt      <= 8'd0;
                        if (w_illegal) begin
                            r_state   <= c_ERR;
                            r_illegal <= 1'b1;
                        end else if (w_misaligned) begin
                            r_state      <= c_ERR;
                            r_misaligned <= 1'b1;
                        end else begin
                            r_state <= c_REQ;
                        end
                    end
                end
                c_REQ: begin
                    // memReady is checked first so data arriving in the last
                    // permitted cycle still completes the load.
                    if (bus.memReady) begin
                        r_sulu  <= w_lane_data;
                        r_state <= c_DONE;
                    end else if (r_cnt + 8'd1 == c_TIMEOUT) begin
                        r_cnt     <= r_cnt + 8'd1;
                        r_bus_err <= 1'b1;
                        r_state   <= c_ERR;
                    end else begin
                        r_cnt <= r_cnt + 8'd1;
                    end
                end
                c_DONE: begin
                    r_sulu  <= '0;
                    r_state <= c_IDLE;
                end
                default: begin
                    r_state <= c_IDLE;
                end
            endcase
        end
    end

    assign bus.memAddr        = r_mem_addr;
    assign bus.memRead        = (r_state == c_REQ);
    assign bus.suluDataIn     = r_sulu;
    assign bus.done           = (r_state == c_DONE);
    assign bus.loadByteSigned = (r_state == c_DONE) && (r_funct3 == 3'b000);
    assign bus.loadHalfSigned = (r_state == c_DONE) && (r_funct3 == 3'b001);
    assign bus.load           = (r_state == c_DONE) && (r_funct3 != 3'b000) &&
                                (r_funct3 != 3'b001);
    assign bus.misaligned     = r_misaligned;
    assign bus.illegalLoad    = r_illegal;
    assign bus.busError       = r_bus_err;
    assign bus.busy           = (r_state != c_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_aftab_load_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_aftab_load_sequencer
// Description : Directed self-checking bench for aftab_load_sequencer with a
//               4-cycle timeout. Cycle n is the cycle after clock edge n,
//               with the accept at edge 0.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_aftab_load_sequencer;

    logic clk;
    logic rst_n;
    int   checks;
    int   errors;

    aftab_load_sequencer_if #(.SIZE(32)) bus ();

    aftab_load_sequencer #(.SIZE(32), .TIMEOUT_CYCLES(4)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    // Drives a one-cycle request; returns positioned in cycle 1.
    task automatic start(input logic [2:0] f3, input logic [31:0] addr);
        bus.startLoad = 1'b1;
        bus.funct3    = f3;
        bus.addrIn    = addr;
        tick();
        bus.startLoad = 1'b0;
    endtask

    function automatic logic [31:0] sulu_out();
        logic [31:0] d;
        d = bus.suluDataIn;
        if (bus.loadByteSigned) return {{24{d[7]}}, d[7:0]};
        if (bus.loadHalfSigned) return {{16{d[15]}}, d[15:0]};
        return d;
    endfunction

    task automatic test_reset();
        chk("rst_memAddr", bus.memAddr, 32'h0);
        chk("rst_memRead", 32'(bus.memRead), 32'h0);
        chk("rst_sulu", bus.suluDataIn, 32'h0);
        chk("rst_done", 32'(bus.done), 32'h0);
        chk("rst_busy", 32'(bus.busy), 32'h0);
        chk("rst_errs", {29'h0, bus.misaligned, bus.illegalLoad, bus.busError}, 32'h0);
    endtask

    task automatic test_lb();
        start(3'b000, 32'h0000_0103);
        chk("lb_memAddr", bus.memAddr, 32'h0000_0100);
        chk("lb_memRead_c1", 32'(bus.memRead), 32'h1);
        tick();
        tick();
        chk("lb_memRead_c3", 32'(bus.memRead), 32'h1);
        bus.memReady  = 1'b1;
        bus.memDataIn = 32'h8012_3456;
        tick();
        bus.memReady = 1'b0;
        chk("lb_done_c4", 32'(bus.done), 32'h1);
        chk("lb_sulu", bus.suluDataIn, 32'h0000_0080);
        chk("lb_selects", {29'h0, bus.loadByteSigned, bus.loadHalfSigned, bus.load}, 32'h4);
        chk("lb_sulu_out", sulu_out(), 32'hFFFF_FF80);
        tick();
        chk("lb_after_done", 32'(bus.done), 32'h0);
        chk("lb_after_sulu", bus.suluDataIn, 32'h0);
        chk("lb_after_busy", 32'(bus.busy), 32'h0);
    endtask

    task automatic test_lhu_lh_lw();
        start(3'b101, 32'h0000_0202);
        bus.memReady  = 1'b1;
        bus.memDataIn = 32'hBEEF_1234;
        tick();
        bus.memReady = 1'b0;
        chk("lhu_done_c2", 32'(bus.done), 32'h1);
        chk("lhu_sulu", bus.suluDataIn, 32'h0000_BEEF);
        chk("lhu_selects", {29'h0, bus.loadByteSigned, bus.loadHalfSigned, bus.load}, 32'h1);
        chk("lhu_sulu_out", sulu_out(), 32'h0000_BEEF);
        tick();
        start(3'b001, 32'h0000_0200);
        bus.memReady  = 1'b1;
        bus.memDataIn = 32'h1234_8001;
        tick();
        bus.memReady = 1'b0;
        chk("lh_sulu", bus.suluDataIn, 32'h0000_8001);
        chk("lh_selects", {29'h0, bus.loadByteSigned, bus.loadHalfSigned, bus.load}, 32'h2);
        chk("lh_sulu_out", sulu_out(), 32'hFFFF_8001);
        tick();
        start(3'b010, 32'h0000_0304);
        bus.memReady  = 1'b1;
        bus.memDataIn = 32'hCAFE_F00D;
        tick();
        bus.memReady = 1'b0;
        chk("lw_sulu", bus.suluDataIn, 32'hCAFE_F00D);
        chk("lw_selects", {29'h0, bus.loadByteSigned, bus.loadHalfSigned, bus.load}, 32'h1);
        tick();
        start(3'b100, 32'h0000_0302);
        bus.memReady  = 1'b1;
        bus.memDataIn = 32'h11C2_3344;
        tick();
        bus.memReady = 1'b0;
        chk("lbu_sulu", bus.suluDataIn, 32'h0000_00C2);
        chk("lbu_selects", {29'h0, bus.loadByteSigned, bus.loadHalfSigned, bus.load}, 32'h1);
        tick();
    endtask

    task automatic test_misaligned();
        start(3'b010, 32'h0000_0301);
        chk("lw_mis_pulse", 32'(bus.misaligned), 32'h1);
        chk("lw_mis_memRead", 32'(bus.memRead), 32'h0);
        chk("lw_mis_busy_c1", 32'(bus.busy), 32'h1);
        tick();
        chk("lw_mis_pulse_c2", 32'(bus.misaligned), 32'h0);
        chk("lw_mis_busy_c2", 32'(bus.busy), 32'h0);
        start(3'b001, 32'h0000_0201);
        chk("lh_mis_pulse", 32'(bus.misaligned), 32'h1);
        chk("lh_mis_memRead", 32'(bus.memRead), 32'h0);
        tick();
        start(3'b000, 32'h0000_0203);
        chk("lb_odd_nomis", 32'(bus.misaligned), 32'h0);
        chk("lb_odd_memRead", 32'(bus.memRead), 32'h1);
        bus.memReady  = 1'b1;
        bus.memDataIn = 32'h7F00_0000;
        tick();
        bus.memReady = 1'b0;
        chk("lb_odd_sulu", bus.suluDataIn, 32'h0000_007F);
        tick();
    endtask

    task automatic test_illegal();
        start(3'b011, 32'h0000_0400);
        chk("ill_pulse", 32'(bus.illegalLoad), 32'h1);
        chk("ill_no_mis", 32'(bus.misaligned), 32'h0);
        chk("ill_memRead", 32'(bus.memRead), 32'h0);
        tick();
        chk("ill_busy_c2", 32'(bus.busy), 32'h0);
        // Illegal has priority over an address that would also be misaligned.
        start(3'b111, 32'h0000_0403);
        chk("ill111_pulse", 32'(bus.illegalLoad), 32'h1);
        chk("ill111_no_mis", 32'(bus.misaligned), 32'h0);
        tick();
    endtask

    task automatic test_ignore_start();
        int ndone;
        start(3'b010, 32'h0000_0500);
        bus.startLoad = 1'b1;
        bus.funct3    = 3'b000;
        bus.addrIn    = 32'h0000_0777;
        tick();
        bus.startLoad = 1'b0;
        chk("ign_memAddr", bus.memAddr, 32'h0000_0500);
        bus.memReady  = 1'b1;
        bus.memDataIn = 32'h0BAD_BEEF;
        tick();
        bus.memReady = 1'b0;
        ndone = 0;
        for (int i = 0; i < 6; i++) begin
            if (bus.done === 1'b1) ndone++;
            tick();
        end
        chk("ign_one_done", 32'(ndone), 32'h1);
    endtask

    task automatic test_timeout();
        start(3'b010, 32'h0000_0600);
        for (int i = 1; i <= 4; i++) begin
            chk("to_memRead", 32'(bus.memRead), 32'h1);
            tick();
        end
        chk("to_busError_c5", 32'(bus.busError), 32'h1);
        chk("to_memRead_c5", 32'(bus.memRead), 32'h0);
        chk("to_done_c5", 32'(bus.done), 32'h0);
        tick();
        chk("to_busError_c6", 32'(bus.busError), 32'h0);
        chk("to_busy_c6", 32'(bus.busy), 32'h0);
        // Ready in the final allowed cycle wins over the timeout.
        start(3'b010, 32'h0000_0600);
        tick();
        tick();
        tick();
        chk("tol_memRead_c4", 32'(bus.memRead), 32'h1);
        bus.memReady  = 1'b1;
        bus.memDataIn = 32'h1357_9BDF;
        tick();
        bus.memReady = 1'b0;
        chk("tol_done_c5", 32'(bus.done), 32'h1);
        chk("tol_busError_c5", 32'(bus.busError), 32'h0);
        chk("tol_sulu", bus.suluDataIn, 32'h1357_9BDF);
        tick();
    endtask

    task automatic test_reset_mid();
        int ndone;
        start(3'b010, 32'h0000_0700);
        tick();
        rst_n = 1'b0;
        #1;
        chk("rmid_memRead", 32'(bus.memRead), 32'h0);
        chk("rmid_busy", 32'(bus.busy), 32'h0);
        chk("rmid_memAddr", bus.memAddr, 32'h0);
        @(negedge clk);
        rst_n         = 1'b1;
        bus.memReady  = 1'b1;
        bus.memDataIn = 32'hFFFF_FFFF;
        ndone = 0;
        for (int i = 0; i < 4; i++) begin
            tick();
            if (bus.done === 1'b1 || bus.memRead === 1'b1) ndone++;
        end
        bus.memReady = 1'b0;
        chk("rmid_no_done", 32'(ndone), 32'h0);
    endtask

    initial begin
        checks        = 0;
        errors        = 0;
        rst_n         = 1'b0;
        bus.startLoad = 1'b0;
        bus.funct3    = 3'b000;
        bus.addrIn    = '0;
        bus.memReady  = 1'b0;
        bus.memDataIn = '0;
        #2;
        test_reset();
        #10;
        rst_n = 1'b1;
        tick();
        test_lb();
        test_lhu_lh_lw();
        test_misaligned();
        test_illegal();
        test_ignore_start();
        test_timeout();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/aftab_load_sequencer.md
# aftab_load_sequencer

Sequences every load instruction through the AFTAB data-memory port and the sign-extension/load unit (SULU). Each accepted request is checked for legality and alignment, then one word-aligned read is issued with a timeout. The block shifts the addressed byte or halfword into bit 0 and masks it for unsigned loads, then drives the SULU select lines for a single result cycle.

## Interface
- size, 32, datapath width; only 32 is supported.
- timeoutCycles, 16, maximum REQ cycles to wait for memReady (legal range 1..255).

- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- startLoad  in  1  request strobe; sampled only in IDLE.
- funct3  in  3  load type: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU; 011/110/111 are illegal.
- addrIn  in  size  byte address of the load.
- memAddr  out  size  word-aligned read address {addr[31:2],2'b00}, registered at accept.
- memRead  out  1  read request; high for all of REQ.
- memReady  in  1  memory has valid memDataIn this cycle.
- memDataIn  in  size  read word.
- suluDataIn  out  size  lane-shifted and masked data for the SULU dataIn.
- loadByteSigned  out  1  SULU select; high in DONE for LB only.
- loadHalfSigned  out  1  SULU select; high in DONE for LH only.
- load  out  1  SULU select; high in DONE for LW, LBU, LHU.
- done  out  1  one-cycle pulse; SULU output is valid this cycle.
- misaligned  out  1  one-cycle pulse on an alignment fault.
- illegalLoad  out  1  one-cycle pulse on an illegal funct3.
- busError  out  1  one-cycle pulse on a timeout.
- busy  out  1  high whenever the state is not IDLE.

## Operation
- States: IDLE, REQ, DONE, ERR.
- IDLE with startLoad=1 latches funct3, addrIn[1:0] and memAddr. The next state is chosen in this priority order:
  - illegal funct3 → ERR with illegalLoad;
  - misaligned → ERR with misaligned (LH/LHU with addr[0]=1; LW with addr[1:0]≠00; byte loads are never misaligned);
  - otherwise → REQ with the wait counter cleared.
- REQ drives memRead=1.
  - memReady=1: capture memDataIn, go to DONE.
  - memReady=0: increment the counter. When the counter reaches timeoutCycles, go to ERR with busError.
  - memReady in the final allowed cycle wins over the timeout.
- DONE asserts done and exactly one SULU select, and drives suluDataIn from the captured word. Always returns to IDLE.
  - Byte loads: the byte is word >> (8·addr[1:0]).
  - Half loads: the half is word >> (16·addr[1]).
  - LB: {24'b0,byte}. LH: {16'b0,half}. The SULU performs the sign extension.
  - LBU: {24'b0,byte} with load=1. LHU: {16'b0,half} with load=1. The zero mask makes the SULU pass-through correct.
  - LW: the captured word, unchanged.
- ERR raises exactly one error pulse for one cycle, then returns to IDLE. memRead is never asserted on a fault.
- startLoad outside IDLE is ignored; there is no queueing. memReady outside REQ is ignored.

## Timing
- Reset (asynchronous, immediate):
  - state IDLE, counter 0;
  - all outputs 0, including memAddr and suluDataIn.
- Reset asserted mid-REQ drops memRead in the same cycle and discards the pending read.
- All outputs are registered or decoded from registered state; there is no combinational path from input to output.
- Accept at clock edge 0. memRead is high starting in cycle 1.
- memReady high in REQ cycle k gives done in cycle k+1. Minimum load latency is 2 cycles from accept to done.
- A fault accepted at edge 0 pulses in cycle 1; busy returns to 0 in cycle 2.
- A timeout holds memRead high for exactly timeoutCycles cycles, then busError pulses in the following cycle.
- A new startLoad is accepted in the cycle after done or after an error pulse, i.e. once busy=0.
- suluDataIn and the selects hold valid values only during DONE; they are 0 in every other state.

## Test plan
- LB, addrIn=0x103, memDataIn=0x80123456, memReady high in the 3rd REQ cycle:
  - memAddr=0x100;
  - done in cycle 4 with suluDataIn=0x00000080 and loadByteSigned=1;
  - SULU output = 0xFFFFFF80.
- LHU, addrIn=0x202, memDataIn=0xBEEF1234, memReady immediate → done in cycle 2 with suluDataIn=0x0000BEEF and load=1; SULU output = 0x0000BEEF.
- LW addrIn=0x301 → misaligned pulses in cycle 1, memRead stays 0. LH addrIn=0x201 → misaligned. LB addrIn=0x203 → accepted normally.
- funct3=011 → illegalLoad pulses in cycle 1 and no read is issued. startLoad pulsed during REQ → ignored, exactly one done.
- timeoutCycles=4, memReady held 0 → memRead high for cycles 1–4, busError in cycle 5, busy=0 in cycle 6. Same setup with memReady in cycle 4 → done, no busError.
- rst low during REQ → memRead=0 and busy=0 immediately. memReady applied after reset is released → no done.
